// File: rtl/fft_pingpong_buffer_2p_if.sv
// Bus bundle for the dual-port ping-pong FFT working memory.
// master = upstream datapath, slave = the buffer itself.
interface fft_pingpong_buffer_2p_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
);
    logic                  rd_en_a;
    logic [ADDR_WIDTH-1:0] rd_addr_a;
    logic                  rd_en_b;
    logic [ADDR_WIDTH-1:0] rd_addr_b;
    logic [DATA_WIDTH-1:0] rd_data_a;
    logic [DATA_WIDTH-1:0] rd_data_b;
    logic                  rd_fmt_a;
    logic                  rd_fmt_b;
    logic                  rd_valid;
    logic                  wr_en_a;
    logic [ADDR_WIDTH-1:0] wr_addr_a;
    logic [DATA_WIDTH-1:0] wr_data_a;
    logic                  wr_en_b;
    logic [ADDR_WIDTH-1:0] wr_addr_b;
    logic [DATA_WIDTH-1:0] wr_data_b;
    logic                  wr_fmt;
    logic                  wr_ready;
    logic                  swap_req;
    logic                  bank_sel;
    logic [ADDR_WIDTH:0]   wr_count;
    logic                  stage_full;
    logic                  swap_done;
    logic                  wr_collision;

    modport master (
        output rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
        output wr_en_a, wr_addr_a, wr_data_a, wr_en_b, wr_addr_b, wr_data_b, wr_fmt,
        output swap_req,
        input  rd_data_a, rd_data_b, rd_fmt_a, rd_fmt_b, rd_valid,
        input  wr_ready, bank_sel, wr_count, stage_full, swap_done, wr_collision
    );

    modport slave (
        input  rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
        input  wr_en_a, wr_addr_a, wr_data_a, wr_en_b, wr_addr_b, wr_data_b, wr_fmt,
        input  swap_req,
        output rd_data_a, rd_data_b, rd_fmt_a, rd_fmt_b, rd_valid,
        output wr_ready, bank_sel, wr_count, stage_full, swap_done, wr_collision
    );
endinterface

// File: rtl/fft_pingpong_buffer_2p.sv
// Ping-pong working memory for the radix-2 FFT: two read and two write ports per bank,
// per-word format tag, write-beat counting and a FILL/SWAP bank exchange FSM.
module fft_pingpong_buffer_2p #(
    parameter int N          = 1024,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = $clog2(N),
    parameter bit AUTO_SWAP  = 1'b0
) (
    input logic clk,
    input logic rst,
    fft_pingpong_buffer_2p_if.slave bus
);
    localparam int CW = ADDR_WIDTH + 1;

    typedef enum logic {FILL, SWAP} state_t;

    // Both banks share one array; the MSB of the index selects the bank.
    logic [DATA_WIDTH-1:0] mem [2*N];
    logic                  fmt_mem [2*N];

    state_t                state_q, state_d;
    logic                  wr_ready_q, wr_ready_d;
    logic                  bank_sel_q, bank_sel_d;
    logic [CW-1:0]         wr_count_q, wr_count_d;
    logic                  swap_done_q, swap_done_d;
    logic                  wr_collision_q, wr_collision_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0] rd_data_a_q, rd_data_a_d;
    logic [DATA_WIDTH-1:0] rd_data_b_q, rd_data_b_d;
    logic                  rd_fmt_a_q, rd_fmt_a_d;
    logic                  rd_fmt_b_q, rd_fmt_b_d;

    logic                  wr_acc_a, wr_acc_b, stage_full;
    logic [1:0]            beats;
    logic [CW-1:0]         count_sum;

    // A write presented during reset must never reach the array.
    assign wr_acc_a   = bus.wr_en_a && wr_ready_q && !rst;
    assign wr_acc_b   = bus.wr_en_b && wr_ready_q && !rst;
    assign beats      = {1'b0, wr_acc_a} + {1'b0, wr_acc_b};
    assign count_sum  = wr_count_q + {{(CW-2){1'b0}}, beats};
    assign stage_full = (wr_count_q == CW'(N));

    always_comb begin
        state_d        = state_q;
        bank_sel_d     = bank_sel_q;
        wr_count_d     = wr_count_q;
        swap_done_d    = 1'b0;
        wr_collision_d = wr_acc_a && wr_acc_b && (bus.wr_addr_a == bus.wr_addr_b);
        rd_valid_d     = bus.rd_en_a | bus.rd_en_b;
        rd_data_a_d    = rd_data_a_q;
        rd_data_b_d    = rd_data_b_q;
        rd_fmt_a_d     = rd_fmt_a_q;
        rd_fmt_b_d     = rd_fmt_b_q;
        case (state_q)
            FILL: begin
                wr_count_d = (count_sum > CW'(N)) ? CW'(N) : count_sum;
                if (bus.swap_req || (AUTO_SWAP && stage_full))
                    state_d = SWAP;
            end
            SWAP: begin
                state_d     = FILL;
                bank_sel_d  = ~bank_sel_q;
                wr_count_d  = '0;
                swap_done_d = 1'b1;
            end
            default: state_d = FILL;
        endcase
        wr_ready_d = (state_d == FILL);
        // Reads use the bank selected at the request edge, so a SWAP-cycle read sees the old bank.
        if (bus.rd_en_a) begin
            rd_data_a_d = mem[{bank_sel_q, bus.rd_addr_a}];
            rd_fmt_a_d  = fmt_mem[{bank_sel_q, bus.rd_addr_a}];
        end
        if (bus.rd_en_b) begin
            rd_data_b_d = mem[{bank_sel_q, bus.rd_addr_b}];
            rd_fmt_b_d  = fmt_mem[{bank_sel_q, bus.rd_addr_b}];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= FILL;
            wr_ready_q     <= 1'b1;
            bank_sel_q     <= 1'b0;
            wr_count_q     <= '0;
            swap_done_q    <= 1'b0;
            wr_collision_q <= 1'b0;
            rd_valid_q     <= 1'b0;
            rd_data_a_q    <= '0;
            rd_data_b_q    <= '0;
            rd_fmt_a_q     <= 1'b0;
            rd_fmt_b_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_ready_q     <= wr_ready_d;
            bank_sel_q     <= bank_sel_d;
            wr_count_q     <= wr_count_d;
            swap_done_q    <= swap_done_d;
            wr_collision_q <= wr_collision_d;
            rd_valid_q     <= rd_valid_d;
            rd_data_a_q    <= rd_data_a_d;
            rd_data_b_q    <= rd_data_b_d;
            rd_fmt_a_q     <= rd_fmt_a_d;
            rd_fmt_b_q     <= rd_fmt_b_d;
        end
    end

    // Port B is written last so it wins when both ports hit the same address.
    always_ff @(posedge clk) begin
        if (wr_acc_a) begin
            mem[{~bank_sel_q, bus.wr_addr_a}]     <= bus.wr_data_a;
            fmt_mem[{~bank_sel_q, bus.wr_addr_a}] <= bus.wr_fmt;
        end
        if (wr_acc_b) begin
            mem[{~bank_sel_q, bus.wr_addr_b}]     <= bus.wr_data_b;
            fmt_mem[{~bank_sel_q, bus.wr_addr_b}] <= bus.wr_fmt;
        end
    end

    assign bus.wr_ready     = wr_ready_q;
    assign bus.bank_sel     = bank_sel_q;
    assign bus.wr_count     = wr_count_q;
    assign bus.stage_full   = stage_full;
    assign bus.swap_done    = swap_done_q;
    assign bus.wr_collision = wr_collision_q;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.rd_data_a    = rd_data_a_q;
    assign bus.rd_data_b    = rd_data_b_q;
    assign bus.rd_fmt_a     = rd_fmt_a_q;
    assign bus.rd_fmt_b     = rd_fmt_b_q;
endmodule

// File: tb/tb_fft_pingpong_buffer_2p.sv
// Directed bench: a 1024-word manual-swap instance and a 16-word auto-swap instance,
// inputs driven and outputs sampled on the falling edge.
module tb_fft_pingpong_buffer_2p;
    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    fft_pingpong_buffer_2p_if #(.DATA_WIDTH(16), .ADDR_WIDTH(10)) b ();
    fft_pingpong_buffer_2p_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4))  s ();

    fft_pingpong_buffer_2p #(.N(1024), .DATA_WIDTH(16), .ADDR_WIDTH(10), .AUTO_SWAP(1'b0)) u_big (
        .clk(clk), .rst(rst), .bus(b));
    fft_pingpong_buffer_2p #(.N(16), .DATA_WIDTH(16), .ADDR_WIDTH(4), .AUTO_SWAP(1'b1)) u_small (
        .clk(clk), .rst(rst), .bus(s));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_big();
        b.rd_en_a = 0; b.rd_addr_a = '0; b.rd_en_b = 0; b.rd_addr_b = '0;
        b.wr_en_a = 0; b.wr_addr_a = '0; b.wr_data_a = '0;
        b.wr_en_b = 0; b.wr_addr_b = '0; b.wr_data_b = '0;
        b.wr_fmt = 0; b.swap_req = 0;
    endtask

    task automatic idle_small();
        s.rd_en_a = 0; s.rd_addr_a = '0; s.rd_en_b = 0; s.rd_addr_b = '0;
        s.wr_en_a = 0; s.wr_addr_a = '0; s.wr_data_a = '0;
        s.wr_en_b = 0; s.wr_addr_b = '0; s.wr_data_b = '0;
        s.wr_fmt = 0; s.swap_req = 0;
    endtask

    // Two-cycle manual swap on the big instance: request, then the SWAP cycle itself.
    task automatic swap_big();
        b.swap_req = 1; tick();
        b.swap_req = 0; tick();
    endtask

    initial begin
        idle_big();
        idle_small();
        rst = 1;
        tick(); tick();
        check("reset_bank_sel", b.bank_sel, 0);
        check("reset_wr_count", b.wr_count, 0);
        check("reset_rd_data_a", b.rd_data_a, 0);
        check("reset_rd_valid", b.rd_valid, 0);
        check("reset_swap_done", b.swap_done, 0);
        check("reset_collision", b.wr_collision, 0);
        check("reset_wr_ready", b.wr_ready, 1);
        check("reset_small_count", s.wr_count, 0);
        rst = 0;

        // Fill bank 1: even addresses on A, odd on B, fp8 tag.
        for (int i = 0; i < 512; i++) begin
            b.wr_en_a = 1; b.wr_addr_a = 10'(2*i);   b.wr_data_a = 16'(2*i);
            b.wr_en_b = 1; b.wr_addr_b = 10'(2*i+1); b.wr_data_b = 16'(2*i+1);
            b.wr_fmt = 1;
            tick();
            if (i == 0) check("fill_first_count", b.wr_count, 2);
        end
        idle_big();
        check("fill_count", b.wr_count, 1024);
        check("fill_stage_full", b.stage_full, 1);
        b.swap_req = 1; tick();
        check("swap_wr_ready_low", b.wr_ready, 0);
        check("swap_bank_old", b.bank_sel, 0);
        b.swap_req = 0; tick();
        check("swap_bank_new", b.bank_sel, 1);
        check("swap_count_clr", b.wr_count, 0);
        check("swap_done_pulse", b.swap_done, 1);
        check("swap_wr_ready_high", b.wr_ready, 1);
        tick();
        check("swap_done_clear", b.swap_done, 0);
        b.rd_en_a = 1; b.rd_addr_a = 10'd5; b.rd_en_b = 1; b.rd_addr_b = 10'd6;
        tick();
        check("rd5_data", b.rd_data_a, 16'h0005);
        check("rd6_data", b.rd_data_b, 16'h0006);
        check("rd5_fmt", b.rd_fmt_a, 1);
        check("rd6_fmt", b.rd_fmt_b, 1);
        check("rd_valid_high", b.rd_valid, 1);
        idle_big(); tick();
        check("rd_valid_low", b.rd_valid, 0);
        check("rd_hold", b.rd_data_a, 16'h0005);

        // Collision on address 3 into bank 0.
        b.wr_en_a = 1; b.wr_addr_a = 10'd3; b.wr_data_a = 16'hAAAA;
        b.wr_en_b = 1; b.wr_addr_b = 10'd3; b.wr_data_b = 16'h5555;
        b.wr_fmt = 1;
        tick();
        idle_big();
        check("coll_pulse", b.wr_collision, 1);
        check("coll_count", b.wr_count, 2);
        tick();
        check("coll_pulse_end", b.wr_collision, 0);
        swap_big();
        check("coll_bank", b.bank_sel, 0);
        b.rd_en_a = 1; b.rd_addr_a = 10'd3; tick();
        idle_big();
        check("coll_winner", b.rd_data_a, 16'h5555);

        // fp4 write into bank 1, then read during SWAP and a swap_req held through SWAP.
        b.wr_en_a = 1; b.wr_addr_a = 10'd7; b.wr_data_a = 16'h1234; b.wr_fmt = 0;
        tick();
        idle_big();
        b.swap_req = 1; tick();
        b.rd_en_a = 1; b.rd_addr_a = 10'd3;
        tick();
        check("swapcyc_rd_old", b.rd_data_a, 16'h5555);
        check("swapcyc_rd_fmt", b.rd_fmt_a, 1);
        check("swapcyc_bank", b.bank_sel, 1);
        b.swap_req = 0; b.rd_en_a = 0; b.rd_en_b = 1; b.rd_addr_b = 10'd7;
        tick();
        idle_big();
        check("no_queued_swap", b.wr_ready, 1);
        check("no_queued_bank", b.bank_sel, 1);
        check("fp4_data", b.rd_data_b, 16'h1234);
        check("fp4_fmt", b.rd_fmt_b, 0);

        // Saturation: 1030 beats into bank 0, the last six wrap over addresses 0..5.
        for (int i = 0; i < 1030; i++) begin
            b.wr_en_a = 1; b.wr_addr_a = 10'(i % 1024); b.wr_data_a = 16'(16'h2000 + i);
            b.wr_fmt = 1;
            tick();
        end
        idle_big();
        check("sat_count", b.wr_count, 1024);
        check("sat_full", b.stage_full, 1);
        swap_big();
        check("sat_bank", b.bank_sel, 0);
        b.rd_en_a = 1; b.rd_addr_a = 10'd0; b.rd_en_b = 1; b.rd_addr_b = 10'd6;
        tick();
        check("sat_rd0", b.rd_data_a, 16'h2400);
        check("sat_rd6", b.rd_data_b, 16'h2006);
        b.rd_addr_a = 10'd5; b.rd_addr_b = 10'd5;
        tick();
        idle_big();
        check("same_addr_a", b.rd_data_a, 16'h2405);
        check("same_addr_b", b.rd_data_b, 16'h2405);

        // Mid-fill reset at 300 beats with bank 1 being read.
        swap_big();
        for (int i = 0; i < 150; i++) begin
            b.wr_en_a = 1; b.wr_addr_a = 10'(2*i);   b.wr_data_a = 16'hC000;
            b.wr_en_b = 1; b.wr_addr_b = 10'(2*i+1); b.wr_data_b = 16'hC001;
            b.rd_en_a = 1; b.rd_addr_a = 10'd7;
            tick();
        end
        check("pre_rst_count", b.wr_count, 300);
        check("pre_rst_bank", b.bank_sel, 1);
        check("pre_rst_rd", b.rd_data_a, 16'h1234);
        rst = 1; tick();
        rst = 0;
        idle_big();
        check("rst_count", b.wr_count, 0);
        check("rst_bank", b.bank_sel, 0);
        check("rst_rd_data", b.rd_data_a, 0);
        check("rst_rd_valid", b.rd_valid, 0);
        check("rst_wr_ready", b.wr_ready, 1);

        // Auto-swap instance: 16 beats trigger SWAP, writes during SWAP are dropped.
        for (int i = 0; i < 8; i++) begin
            s.wr_en_a = 1; s.wr_addr_a = 4'(2*i);   s.wr_data_a = 16'(16'h0100 + 2*i);
            s.wr_en_b = 1; s.wr_addr_b = 4'(2*i+1); s.wr_data_b = 16'(16'h0101 + 2*i);
            s.wr_fmt = 1;
            tick();
        end
        idle_small();
        check("auto_count", s.wr_count, 16);
        check("auto_full", s.stage_full, 1);
        tick();
        check("auto_swap_ready", s.wr_ready, 0);
        s.wr_en_a = 1; s.wr_addr_a = 4'd0; s.wr_data_a = 16'hDEAD;
        s.wr_en_b = 1; s.wr_addr_b = 4'd1; s.wr_data_b = 16'hBEEF;
        tick();
        idle_small();
        check("auto_bank", s.bank_sel, 1);
        check("auto_count_clr", s.wr_count, 0);
        check("auto_done", s.swap_done, 1);
        s.rd_en_a = 1; s.rd_addr_a = 4'd0; s.rd_en_b = 1; s.rd_addr_b = 4'd1;
        tick();
        idle_small();
        check("auto_drop_a", s.rd_data_a, 16'h0100);
        check("auto_drop_b", s.rd_data_b, 16'h0101);
        s.wr_en_a = 1; s.wr_addr_a = 4'd2; s.wr_data_a = 16'h0042;
        tick();
        idle_small();
        check("auto_next_count", s.wr_count, 1);
        check("auto_next_ready", s.wr_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
